// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken-branch flush and load-use stall, driving registered pipeline controls.
module pipeline_hazard_controller #(
   parameter int unsigned REG_ADDR_W    = 4,
   parameter logic [3:0]  BRANCH_OPCODE = 4'b1011,
   parameter int unsigned FLUSH_CYCLES  = 2,
   parameter int unsigned MEM_TIMEOUT   = 15
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  idex_memread,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs1,
   input  logic [REG_ADDR_W-1:0] ifid_rs2,
   input  logic                  ifid_uses_rs2,
   input  logic [3:0]            exmem_opcode,
   input  logic                  exmem_zero,
   input  logic                  mem_req,
   input  logic                  mem_ack,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  idex_bubble,
   output logic                  flush,
   output logic                  mem_stall,
   output logic                  mem_timeout_err,
   output logic [15:0]           stall_count
);

   localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned SCNT_W = 16;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                prev_ls_q;
   logic                err_q, err_d;
   logic                pc_we_q, pc_we_d;
   logic                ifid_we_q, ifid_we_d;
   logic                bubble_q, bubble_d;
   logic                flush_q, flush_d;
   logic                mem_stall_q, mem_stall_d;
   logic [SCNT_W-1:0]   scnt_q, scnt_d;

   logic branch_taken_c;
   logic load_use_c;

   assign branch_taken_c = (exmem_opcode == BRANCH_OPCODE) && !exmem_zero;
   assign load_use_c     = idex_memread && (idex_rd != '0) &&
                           ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

   // Next-state arbitration and output decode of the state being entered
   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      wcnt_d      = wcnt_q;
      err_d       = err_q;
      pc_we_d     = 1'b1;
      ifid_we_d   = 1'b1;
      bubble_d    = 1'b0;
      flush_d     = 1'b0;
      mem_stall_d = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req && !mem_ack) begin
               state_d = ST_MEM_WAIT;
               wcnt_d  = WCNT_W'(1);
            end else if (branch_taken_c) begin
               state_d = ST_FLUSH;
               fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
            end else if (load_use_c && !prev_ls_q) begin
               state_d = ST_LOAD_STALL;
            end
         end
         ST_LOAD_STALL: state_d = ST_RUN;
         ST_FLUSH: begin
            if (fcnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               fcnt_d = fcnt_q - FCNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            // An ack arriving on the timeout cycle still completes cleanly
            if (mem_ack) begin
               state_d = ST_RUN;
            end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = ST_RUN;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase

      case (state_d)
         ST_LOAD_STALL: begin
            pc_we_d   = 1'b0;
            ifid_we_d = 1'b0;
            bubble_d  = 1'b1;
         end
         ST_FLUSH: begin
            bubble_d = 1'b1;
            flush_d  = 1'b1;
         end
         ST_MEM_WAIT: begin
            pc_we_d     = 1'b0;
            ifid_we_d   = 1'b0;
            mem_stall_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Saturating count of cycles in which the PC was held
   always_comb begin
      scnt_d = scnt_q;
      if (!pc_we_q && (scnt_q != {SCNT_W{1'b1}})) begin
         scnt_d = scnt_q + SCNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         fcnt_q      <= '0;
         wcnt_q      <= '0;
         prev_ls_q   <= 1'b0;
         err_q       <= 1'b0;
         pc_we_q     <= 1'b1;
         ifid_we_q   <= 1'b1;
         bubble_q    <= 1'b0;
         flush_q     <= 1'b0;
         mem_stall_q <= 1'b0;
         scnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         wcnt_q      <= wcnt_d;
         prev_ls_q   <= (state_q == ST_LOAD_STALL);
         err_q       <= err_d;
         pc_we_q     <= pc_we_d;
         ifid_we_q   <= ifid_we_d;
         bubble_q    <= bubble_d;
         flush_q     <= flush_d;
         mem_stall_q <= mem_stall_d;
         scnt_q      <= scnt_d;
      end
   end

   assign pc_write_en     = pc_we_q;
   assign ifid_write_en   = ifid_we_q;
   assign idex_bubble     = bubble_q;
   assign flush           = flush_q;
   assign mem_stall       = mem_stall_q;
   assign mem_timeout_err = err_q;
   assign stall_count     = scnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipelined processor.
- Replaces the per-cycle hazard detection unit with an explicit FSM that arbitrates three hazard sources:
  - multi-cycle data-memory wait
  - taken-branch flush
  - load-use stall
- Drives PC / IF-ID write enables, the ID-EX bubble and the flush line.
- Sits beside the pipeline registers and consumes decoded fields from IF/ID, ID/EX and EX/MEM.

Parameters:
- REG_ADDR_W, 4, register-specifier width (16 registers; r0 hardwired zero).
- BRANCH_OPCODE, 4'b1011, EX/MEM opcode that branches when zero == 0.
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken branch (must be ≥ 1).
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort (must be ≥ 1).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- idex_memread, input, 1, instruction in ID/EX is a load.
- idex_rd, input, REG_ADDR_W, destination register of the ID/EX instruction.
- ifid_rs1, input, REG_ADDR_W, source register 1 of the IF/ID instruction.
- ifid_rs2, input, REG_ADDR_W, source register 2 of the IF/ID instruction.
- ifid_uses_rs2, input, 1, IF/ID instruction reads rs2.
- exmem_opcode, input, 4, opcode of the EX/MEM instruction.
- exmem_zero, input, 1, ALU zero flag latched in EX/MEM.
- mem_req, input, 1, data memory access in progress (MEM stage).
- mem_ack, input, 1, data memory completes this cycle.
- pc_write_en, output, 1, 1 = PC may update.
- ifid_write_en, output, 1, 1 = IF/ID register may load.
- idex_bubble, output, 1, 1 = load NOP into ID/EX.
- flush, output, 1, 1 = squash IF/ID and ID/EX contents.
- mem_stall, output, 1, 1 = whole pipeline frozen for memory.
- mem_timeout_err, output, 1, sticky memory-timeout flag.
- stall_count, output, 16, saturating count of cycles with pc_write_en == 0.

Behaviour:
- All outputs are registered: a decision made at edge N is visible from N to N+1. The pipeline is built for this one-cycle latency.
- Reset (reset_n low, asynchronous, effective immediately and also mid-operation):
  - state = RUN
  - pc_write_en = 1, ifid_write_en = 1
  - idex_bubble = 0, flush = 0, mem_stall = 0
  - mem_timeout_err = 0, stall_count = 0
  - internal counters cleared
- Definitions:
  - branch_taken = (exmem_opcode == BRANCH_OPCODE) && !exmem_zero
  - load_use = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2))
- States: RUN, LOAD_STALL, FLUSH, MEM_WAIT. Priority in RUN: memory > branch > load-use.
- RUN:
  - Outputs: enables = 1, bubble = 0, flush = 0, mem_stall = 0.
  - mem_req && !mem_ack → MEM_WAIT; wait counter = 1.
  - Else branch_taken → FLUSH; flush counter = FLUSH_CYCLES−1.
  - Else load_use, and the previous state was not LOAD_STALL → LOAD_STALL.
- LOAD_STALL:
  - Outputs: pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1.
  - Lasts exactly one cycle, then → RUN.
  - load_use is suppressed for the first RUN cycle after LOAD_STALL, so a single load never stalls twice.
- FLUSH:
  - Outputs: flush = 1, idex_bubble = 1, pc_write_en = 1 (branch target load), ifid_write_en = 1.
  - branch_taken and load_use are ignored, since the instructions are being squashed.
  - At flush counter 0 → RUN; otherwise decrement.
  - mem_req is not expected here. If asserted, MEM_WAIT entry is deferred until RUN.
- MEM_WAIT:
  - Outputs: pc_write_en = 0, ifid_write_en = 0, idex_bubble = 0, mem_stall = 1.
  - mem_ack → RUN. A branch in EX/MEM is re-evaluated in that RUN cycle (EX/MEM is frozen).
  - Wait counter reaches MEM_TIMEOUT without ack → set mem_timeout_err (sticky until reset) → RUN.
  - mem_ack and timeout in the same cycle: ack wins, no error.
- stall_count: +1 on every cycle whose registered pc_write_en is 0; holds at 16'hFFFF.

Test Plan:
- Load r3 in ID/EX (idex_memread = 1, idex_rd = 3), IF/ID rs1 = 3 → exactly one cycle of pc_write_en = 0 / ifid_write_en = 0 / idex_bubble = 1, then RUN; stall_count = 1. Repeat with idex_rd = 0 → no stall.
- exmem_opcode = 4'b1011, exmem_zero = 0 with FLUSH_CYCLES = 2 → flush = 1 for exactly 2 cycles, pc_write_en = 1 throughout. exmem_zero = 1 → no flush.
- Branch taken and load_use in the same cycle → FLUSH only, no LOAD_STALL afterwards.
- mem_req = 1, mem_ack after 4 cycles → mem_stall = 1 for 4 cycles, all enables 0, stall_count = 4; branch pending in EX/MEM then flushes.
- mem_req held, no ack, MEM_TIMEOUT = 15 → mem_timeout_err rises after 15 wait cycles and stays set; state returns to RUN.
- Assert reset_n low mid-FLUSH and mid-MEM_WAIT (not edge-aligned) → outputs return to reset values immediately, without waiting for a clock edge.
